// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU issue/sequencing slice: the 3-bit ALU control
// codes (same encoding ALU_Control produces and the ALU consumes) and the
// sequencer state encodings.
package alu_seq_pkg;

  // ALU control codes
  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SRAI    = 3'b001;
  localparam logic [2:0] ALU_SUB     = 3'b010;
  localparam logic [2:0] ALU_MUL     = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_AND     = 3'b101;
  localparam logic [2:0] ALU_ILLEGAL = 3'b110;
  localparam logic [2:0] ALU_SLL     = 3'b111;

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/alu_exec_sequencer_mul_step.sv
// mul_step
// Purely combinational single iteration of the shift-add multiplier. Retires
// BITS_PER_CYCLE multiplier bits: every set bit i of the multiplier adds the
// multiplicand shifted by i into the accumulator, then the multiplicand moves
// left and the multiplier moves right by BITS_PER_CYCLE.
// Ports:
//   acc_i / acc_o       running partial product (modulo 2^WIDTH)
//   mcand_i / mcand_o   multiplicand, pre-aligned to the current bit position
//   mplier_i / mplier_o remaining multiplier bits, LSB is the next bit to retire
module mul_step
  #(parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1)
  (input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0] mplier_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] mcand_o,
   output logic [WIDTH-1:0] mplier_o);

  // Accumulate the partial products for this group of multiplier bits.
  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

  assign mcand_o  = mcand_i << BITS_PER_CYCLE;
  assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer
// Issue/sequencing controller between decode and the ALU datapath. Single-cycle
// ops are computed combinationally and registered on the accept edge; MUL runs
// as an iterative shift-add sequence through mul_step. Results leave over a
// valid/ready handshake and stall_o back-pressures the pipeline.
// Optional build macro: MUL_EARLY_EXIT_EN -- finish a MUL as soon as the
// remaining multiplier bits are all zero (result value unchanged).
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   valid_i / ready_o       op request handshake
//   ALUCtrl_i               3-bit ALU control code
//   data1_i, data2_i        operands A and B (shift amount = B low bits)
//   flush_i                 abort in-flight op and drop any pending result
//   result_o, illegal_o     result and illegal-code flag, qualified by result_valid_o
//   result_valid_o / result_ready_i  result handshake
//   stall_o                 valid_i & ~ready_o
module alu_exec_sequencer
  import alu_seq_pkg::*;
  #(parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1)
  (input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] result_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic             illegal_o,
   output logic             stall_o);

  localparam int STEPS   = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W   = $clog2(STEPS + 1);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0]   stepAcc, stepMcand, stepMplier;
  logic [WIDTH-1:0]   aluResult;
  logic [SHAMT_W-1:0] shiftAmt;
  logic               accept;
  logic               earlyExit;

  mul_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul_step
    (.acc_i   (acc_q),
     .mcand_i (mcand_q),
     .mplier_i(mplier_q),
     .acc_o   (stepAcc),
     .mcand_o (stepMcand),
     .mplier_o(stepMplier));

  // A DONE slot can take the next op in the same cycle its result is consumed,
  // which is what lets single-cycle ops stream at one per cycle.
  assign ready_o        = (state_q == S_IDLE) | ((state_q == S_DONE) & result_ready_i);
  assign stall_o        = valid_i & ~ready_o;
  assign accept         = valid_i & ready_o & ~flush_i;
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;
  assign illegal_o      = illegal_q;
  assign shiftAmt       = data2_i[SHAMT_W-1:0];

`ifdef MUL_EARLY_EXIT_EN
  // Checked before the step: once no multiplier bits remain, acc is final.
  assign earlyExit = (mplier_q == '0);
`else
  assign earlyExit = 1'b0;
`endif

  // Single-cycle datapath. MUL and the illegal code produce zero here; MUL
  // takes its result from the iterative path instead.
  always_comb begin
    aluResult = '0;
    case (ALUCtrl_i)
      ALU_ADD:  aluResult = data1_i + data2_i;
      ALU_SUB:  aluResult = data1_i - data2_i;
      ALU_XOR:  aluResult = data1_i ^ data2_i;
      ALU_AND:  aluResult = data1_i & data2_i;
      ALU_SRAI: aluResult = $unsigned($signed(data1_i) >>> shiftAmt);
      ALU_SLL:  aluResult = data1_i << shiftAmt;
      default:  aluResult = '0;
    endcase
  end

  // Next-state logic. Flush wins over everything and drops any pending result.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    if (flush_i) begin
      state_d   = S_IDLE;
      illegal_d = 1'b0;
    end else if (state_q == S_MUL) begin
      if (earlyExit) begin
        state_d  = S_DONE;
        result_d = acc_q;
      end else if (cnt_q == CNT_W'(1)) begin
        state_d  = S_DONE;
        result_d = stepAcc;
      end else begin
        acc_d    = stepAcc;
        mcand_d  = stepMcand;
        mplier_d = stepMplier;
        cnt_d    = cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      illegal_d = 1'b0;
      if (ALUCtrl_i == ALU_MUL) begin
        state_d  = S_MUL;
        acc_d    = '0;
        mcand_d  = data1_i;
        mplier_d = data2_i;
        cnt_d    = CNT_W'(STEPS);
      end else begin
        state_d   = S_DONE;
        result_d  = aluResult;
        illegal_d = (ALUCtrl_i == ALU_ILLEGAL);
      end
    end else if ((state_q == S_DONE) && result_ready_i) begin
      state_d = S_IDLE;
    end
  end

  // State registers with synchronous active-low reset; a reset mid-MUL simply
  // drops the partial product.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer
// Directed bench for alu_exec_sequencer. A WIDTH=32, BITS_PER_CYCLE=1 instance
// is the main device; a BITS_PER_CYCLE=4 instance shares the same inputs and is
// only examined for its MUL latency. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point.
module tb_alu_exec_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i;
  logic        flush_i;
  logic        result_ready_i;

  logic        ready_o, result_valid_o, illegal_o, stall_o;
  logic [31:0] result_o;
  logic        ready4, resultValid4, illegal4, stall4;
  logic [31:0] result4;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut
    (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
     .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
     .flush_i(flush_i), .result_o(result_o), .result_valid_o(result_valid_o),
     .result_ready_i(result_ready_i), .illegal_o(illegal_o), .stall_o(stall_o));

  alu_exec_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4
    (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready4),
     .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
     .flush_i(flush_i), .result_o(result4), .result_valid_o(resultValid4),
     .result_ready_i(result_ready_i), .illegal_o(illegal4), .stall_o(stall4));

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive an op request onto the shared inputs (no clocking).
  task automatic applyStimulus(input logic valid, input logic [2:0] code,
                               input logic [31:0] a, input logic [31:0] b);
    valid_i   = valid;
    ALUCtrl_i = code;
    data1_i   = a;
    data2_i   = b;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called just after an accept edge; returns how many edges (accept edge
  // counted as 1) until result_valid_o, or 0 if the budget ran out.
  task automatic waitResult(input int limit, output int lat, output logic [31:0] res);
    lat = 0;
    res = '0;
    for (int c = 1; c <= limit && lat == 0; c++) begin
      if (result_valid_o) begin
        lat = c;
        res = result_o;
      end else begin
        tick();
      end
    end
  endtask

  int          lat1, lat4;
  logic [31:0] res1, res4;

  initial begin
    // 1: reset held low with a request pending
    rst_i          = 1'b0;
    flush_i        = 1'b0;
    result_ready_i = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'd1, 32'd2);
    repeat (3) tick();
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_valid", 32'(result_valid_o), 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_illegal", 32'(illegal_o), 32'd0);
    rst_i = 1'b1;
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
    tick();

    // 2: add then sub back-to-back at one op per cycle
    applyStimulus(1'b1, 3'b000, 32'd7, 32'd5);
    #1 checkOutput("add_stall", 32'(stall_o), 32'd0);
    tick();
    checkOutput("add_valid", 32'(result_valid_o), 32'd1);
    checkOutput("add_result", result_o, 32'd12);
    applyStimulus(1'b1, 3'b010, 32'd3, 32'd5);
    #1 checkOutput("sub_stall", 32'(stall_o), 32'd0);
    tick();
    checkOutput("sub_valid", 32'(result_valid_o), 32'd1);
    checkOutput("sub_result", result_o, 32'hFFFF_FFFE);

    // 3: shifts and the illegal code, still streaming
    applyStimulus(1'b1, 3'b001, 32'h8000_0010, 32'd4);
    tick();
    checkOutput("srai_result", result_o, 32'hF800_0001);
    applyStimulus(1'b1, 3'b111, 32'd1, 32'd31);
    tick();
    checkOutput("sll_result", result_o, 32'h8000_0000);
    applyStimulus(1'b1, 3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF);
    tick();
    checkOutput("xor_result", result_o, 32'hFF00_EDCB);
    applyStimulus(1'b1, 3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF);
    tick();
    checkOutput("and_result", result_o, 32'h00F0_1234);
    applyStimulus(1'b1, 3'b110, 32'h1234_5678, 32'd9);
    tick();
    checkOutput("ill_valid", 32'(result_valid_o), 32'd1);
    checkOutput("ill_flag", 32'(illegal_o), 32'd1);
    checkOutput("ill_result", result_o, 32'd0);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    checkOutput("idle_valid", 32'(result_valid_o), 32'd0);

    // 4: mul latency on both instances, stall while busy
    applyStimulus(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd3);
    tick();
    checkOutput("mul_ready", 32'(ready_o), 32'd0);
    checkOutput("mul_stall", 32'(stall_o), 32'd1);
    valid_i = 1'b0;
    lat1 = 0;
    lat4 = 0;
    res1 = '0;
    res4 = '0;
    for (int c = 1; c <= 40 && lat1 == 0; c++) begin
      if (resultValid4 && lat4 == 0) begin
        lat4 = c;
        res4 = result4;
      end
      if (result_valid_o) begin
        lat1 = c;
        res1 = result_o;
      end else begin
        tick();
      end
    end
    checkOutput("mul_lat", 32'(lat1), 32'd33);
    checkOutput("mul_result", res1, 32'hFFFF_FFFD);
    checkOutput("mul4_lat", 32'(lat4), 32'd9);
    checkOutput("mul4_result", res4, 32'hFFFF_FFFD);
    tick();

    // 5: result held while the consumer is not ready
    result_ready_i = 1'b0;
    applyStimulus(1'b1, 3'b011, 32'd5, 32'd4);
    tick();
    valid_i = 1'b0;
    waitResult(40, lat1, res1);
    checkOutput("hold_lat", 32'(lat1), 32'd33);
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_result", result_o, 32'd20);
      checkOutput("hold_valid", 32'(result_valid_o), 32'd1);
      checkOutput("hold_ready", 32'(ready_o), 32'd0);
      tick();
    end
    result_ready_i = 1'b1;
    #1 checkOutput("release_ready", 32'(ready_o), 32'd1);
    tick();
    checkOutput("release_valid", 32'(result_valid_o), 32'd0);

    // 6: flush mid-mul, then a clean mul
    applyStimulus(1'b1, 3'b011, 32'd100, 32'd200);
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("flush_valid", 32'(result_valid_o), 32'd0);
    checkOutput("flush_ready", 32'(ready_o), 32'd1);
    applyStimulus(1'b1, 3'b011, 32'd6, 32'd7);
    tick();
    valid_i = 1'b0;
    waitResult(40, lat1, res1);
    checkOutput("post_flush_lat", 32'(lat1), 32'd33);
    checkOutput("post_flush_result", res1, 32'd42);
    tick();

    // Zero multiplier: short only when early exit is built in
    applyStimulus(1'b1, 3'b011, 32'd9, 32'd0);
    tick();
    valid_i = 1'b0;
    waitResult(40, lat1, res1);
`ifdef MUL_EARLY_EXIT_EN
    checkOutput("mul_zero_lat", 32'(lat1), 32'd2);
`else
    checkOutput("mul_zero_lat", 32'(lat1), 32'd33);
`endif
    checkOutput("mul_zero_result", res1, 32'd0);
    tick();

    // Reset mid-mul leaves no partial result
    applyStimulus(1'b1, 3'b011, 32'd3, 32'd3);
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    checkOutput("rst_mul_valid", 32'(result_valid_o), 32'd0);
    checkOutput("rst_mul_result", result_o, 32'd0);
    repeat (40) begin
      if (result_valid_o) checkOutput("rst_mul_stale", 32'(result_valid_o), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
